// File: rtl/obstacle_run_extractor_pkg.sv
// Shared types and default constants for the obstacle run extractor.
// The record struct is sized for the default widths.
package obstacle_run_extractor_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int IDX_WIDTH_DEF  = 12;
    localparam int MIN_LEN_DEF    = 3;
    localparam int GAP_TOL_DEF    = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_OBJ,
        ST_GAP
    } run_state_t;

    typedef struct packed {
        logic [IDX_WIDTH_DEF-1:0]  start_idx;
        logic [IDX_WIDTH_DEF-1:0]  len;
        logic [DATA_WIDTH_DEF-1:0] r_min;
    } run_rec_t;

endpackage

// File: rtl/obstacle_run_extractor_if.sv
// Point stream in from ground segmentation, run records out to clustering.
// The extractor uses the slave view; the driver of the stream uses the master view.
interface obstacle_run_extractor_if
    import obstacle_run_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF
);
    logic                  seg_valid_in;
    logic                  seg_is_ground;
    logic [DATA_WIDTH-1:0] seg_r_in;
    logic                  frame_start;
    logic                  obj_valid;
    logic                  obj_ready;
    logic [IDX_WIDTH-1:0]  obj_start_idx;
    logic [IDX_WIDTH-1:0]  obj_len;
    logic [DATA_WIDTH-1:0] obj_r_min;
    logic                  overflow;

    modport master (
        output seg_valid_in, seg_is_ground, seg_r_in, frame_start, obj_ready,
        input  obj_valid, obj_start_idx, obj_len, obj_r_min, overflow
    );

    modport slave (
        input  seg_valid_in, seg_is_ground, seg_r_in, frame_start, obj_ready,
        output obj_valid, obj_start_idx, obj_len, obj_r_min, overflow
    );
endinterface

// File: rtl/obstacle_run_extractor_fifo.sv
// Count-based circular record queue; a push into a full queue is accepted
// only when a pop happens in the same cycle, otherwise it is dropped and flagged.
module run_record_fifo
    import obstacle_run_extractor_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = 2 * IDX_WIDTH_DEF + DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             dropped
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign valid    = (count != '0);
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && full && !do_pop;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Cleared so the head outputs read zero out of reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/obstacle_run_extractor.sv
// Groups consecutive non-ground points into runs, bridging short ground gaps,
// and queues qualifying run records {start, len, r_min} for the consumer.
//
//   state     | meaning
//   ST_GROUND | no run open
//   ST_OBJ    | run open, last point non-ground
//   ST_GAP    | run open, inside a tolerated ground gap (gap_q points so far)
module obstacle_run_extractor
    import obstacle_run_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
    parameter int MIN_LEN    = MIN_LEN_DEF,
    parameter int GAP_TOL    = GAP_TOL_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    obstacle_run_extractor_if.slave bus
);
    localparam int                   REC_W     = 2 * IDX_WIDTH + DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] MIN_LEN_W = IDX_WIDTH'(MIN_LEN);
    localparam logic [IDX_WIDTH-1:0] GAP_TOL_W = IDX_WIDTH'(GAP_TOL);
    localparam logic [IDX_WIDTH-1:0] ONE_W     = IDX_WIDTH'(1);

    run_state_t            state, eff_state, nxt_state;
    logic [IDX_WIDTH-1:0]  idx, cur_idx;
    logic [IDX_WIDTH-1:0]  start_q, len_q, gap_q;
    logic [IDX_WIDTH-1:0]  nxt_start, nxt_len, nxt_gap;
    logic [DATA_WIDTH-1:0] rmin_q, nxt_rmin;
    logic                  close_run;
    logic                  push;
    logic                  dropped;
    logic                  overflow_q;
    logic [REC_W-1:0]      head;

    function automatic logic [IDX_WIDTH-1:0] sat_add(input logic [IDX_WIDTH-1:0] a,
                                                     input logic [IDX_WIDTH-1:0] b);
        logic [IDX_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[IDX_WIDTH] ? '1 : s[IDX_WIDTH-1:0];
    endfunction

    always_comb begin
        // A frame start closes any open run, then the sample is handled from GROUND.
        cur_idx   = bus.frame_start ? '0 : idx;
        eff_state = bus.frame_start ? ST_GROUND : state;
        close_run = bus.frame_start && (state != ST_GROUND);
        nxt_state = eff_state;
        nxt_start = start_q;
        nxt_len   = len_q;
        nxt_gap   = gap_q;
        nxt_rmin  = rmin_q;
        case (eff_state)
            ST_GROUND: begin
                if (!bus.seg_is_ground) begin
                    nxt_state = ST_OBJ;
                    nxt_start = cur_idx;
                    nxt_len   = ONE_W;
                    nxt_rmin  = bus.seg_r_in;
                    nxt_gap   = '0;
                end
            end
            ST_OBJ: begin
                if (!bus.seg_is_ground) begin
                    nxt_len  = sat_add(len_q, ONE_W);
                    nxt_rmin = (bus.seg_r_in < rmin_q) ? bus.seg_r_in : rmin_q;
                end else if (GAP_TOL == 0) begin
                    close_run = 1'b1;
                    nxt_state = ST_GROUND;
                end else begin
                    nxt_state = ST_GAP;
                    nxt_gap   = ONE_W;
                end
            end
            ST_GAP: begin
                if (!bus.seg_is_ground) begin
                    nxt_state = ST_OBJ;
                    nxt_len   = sat_add(len_q, gap_q + ONE_W);
                    nxt_rmin  = (bus.seg_r_in < rmin_q) ? bus.seg_r_in : rmin_q;
                end else if (gap_q < GAP_TOL_W) begin
                    nxt_gap = gap_q + ONE_W;
                end else begin
                    close_run = 1'b1;
                    nxt_state = ST_GROUND;
                end
            end
            default: nxt_state = ST_GROUND;
        endcase
    end

    assign push = bus.seg_valid_in && close_run && (len_q >= MIN_LEN_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_GROUND;
            idx        <= '0;
            start_q    <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            rmin_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.seg_valid_in) begin
                state   <= nxt_state;
                idx     <= cur_idx + ONE_W;
                start_q <= nxt_start;
                len_q   <= nxt_len;
                gap_q   <= nxt_gap;
                rmin_q  <= nxt_rmin;
            end
            if (dropped) overflow_q <= 1'b1;
        end
    end

    run_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({start_q, len_q, rmin_q}),
        .pop       (bus.obj_ready),
        .pop_data  (head),
        .valid     (bus.obj_valid),
        .dropped   (dropped)
    );

    assign bus.obj_start_idx = head[REC_W-1 -: IDX_WIDTH];
    assign bus.obj_len       = head[DATA_WIDTH +: IDX_WIDTH];
    assign bus.obj_r_min     = head[DATA_WIDTH-1:0];
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_obstacle_run_extractor.sv
// Directed and random stimulus for obstacle_run_extractor, checked each cycle
// against a position-based run model and a record queue.
module tb_obstacle_run_extractor;
    import obstacle_run_extractor_pkg::*;

    localparam int MIN_LEN = MIN_LEN_DEF;
    localparam int GAP_TOL = GAP_TOL_DEF;
    localparam int DEPTH   = FIFO_DEPTH_DEF;
    localparam int IDX_MAX = 4095;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    obstacle_run_extractor_if #(.DATA_WIDTH(16), .IDX_WIDTH(12)) bus();

    obstacle_run_extractor #(
        .DATA_WIDTH (16),
        .IDX_WIDTH  (12),
        .MIN_LEN    (MIN_LEN),
        .GAP_TOL    (GAP_TOL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a run spans from its first to its last non-ground
    // position; it ends once more than GAP_TOL ground points follow.
    run_rec_t mq[$];
    bit m_ovf, m_open;
    int m_idx, m_pos, m_start_pos, m_last_pos, m_start_idx, m_trail, m_rmin;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_open = 0; m_idx = 0; m_pos = 0; m_trail = 0;
    endtask

    task automatic finish_run(output bit have, output run_rec_t rec);
        int len;
        len = m_last_pos - m_start_pos + 1;
        if (len > IDX_MAX) len = IDX_MAX;
        m_open = 0;
        have = 0;
        rec = '0;
        if (len >= MIN_LEN) begin
            have = 1;
            rec.start_idx = 12'(m_start_idx);
            rec.len       = 12'(len);
            rec.r_min     = 16'(m_rmin);
        end
    endtask

    task automatic model_sample(bit g, int r, bit fs, output bit have, output run_rec_t rec);
        have = 0;
        rec = '0;
        if (fs) begin
            if (m_open) finish_run(have, rec);
            m_idx = 0;
        end
        if (!g) begin
            if (!m_open) begin
                m_open = 1; m_start_idx = m_idx; m_start_pos = m_pos; m_rmin = r;
            end else if (r < m_rmin) begin
                m_rmin = r;
            end
            m_last_pos = m_pos;
            m_trail = 0;
        end else if (m_open) begin
            m_trail++;
            if (m_trail > GAP_TOL) finish_run(have, rec);
        end
        m_idx = (m_idx + 1) % (IDX_MAX + 1);
        m_pos++;
    endtask

    task automatic check_outputs();
        check("obj_valid", 32'(bus.obj_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("obj_start_idx", 32'(bus.obj_start_idx), 32'(mq[0].start_idx));
            check("obj_len", 32'(bus.obj_len), 32'(mq[0].len));
            check("obj_r_min", 32'(bus.obj_r_min), 32'(mq[0].r_min));
        end
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc(bit v, bit g, int r, bit fs, bit rdy);
        bit have, pop_now;
        run_rec_t rec;
        bus.seg_valid_in  = v;
        bus.seg_is_ground = g;
        bus.seg_r_in      = 16'(r);
        bus.frame_start   = fs;
        bus.obj_ready     = rdy;
        @(posedge clk);
        have = 0;
        rec = '0;
        if (v) model_sample(g, r, fs, have, rec);
        pop_now = (mq.size() != 0) && rdy;
        if (pop_now) void'(mq.pop_front());
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(rec);
            else m_ovf = 1;
        end
        #1;
        check_outputs();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_valid"}, 32'(bus.obj_valid), 0);
        check({tag, "_start"}, 32'(bus.obj_start_idx), 0);
        check({tag, "_len"}, 32'(bus.obj_len), 0);
        check({tag, "_rmin"}, 32'(bus.obj_r_min), 0);
        check({tag, "_ovf"}, 32'(bus.overflow), 0);
    endtask

    task automatic check_head(string tag, int s, int l);
        check({tag, "_valid"}, 32'(bus.obj_valid), 1);
        check({tag, "_start"}, 32'(bus.obj_start_idx), 32'(s));
        check({tag, "_len"}, 32'(bus.obj_len), 32'(l));
    endtask

    initial begin
        bus.seg_valid_in = 0; bus.seg_is_ground = 0; bus.seg_r_in = '0;
        bus.frame_start = 0; bus.obj_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Basic run at idx 2..4, closed by the second trailing ground point
        cyc(1, 1, 500, 0, 1); cyc(1, 1, 500, 0, 1);
        cyc(1, 0, 100, 0, 1); cyc(1, 0, 80, 0, 1); cyc(1, 0, 90, 0, 1);
        cyc(1, 1, 7, 0, 1);
        check("basic_not_yet", 32'(bus.obj_valid), 0);
        cyc(1, 1, 7, 0, 1);
        check_head("basic", 2, 3);
        check("basic_rmin", 32'(bus.obj_r_min), 80);

        // Short run rejected
        cyc(1, 1, 5, 0, 1); cyc(1, 0, 5, 0, 1); cyc(1, 0, 5, 0, 1);
        cyc(1, 1, 5, 0, 1); cyc(1, 1, 5, 0, 1);
        check("short_none", 32'(bus.obj_valid), 0);

        // Gap bridging from idx 0; ground range 1 must not reach r_min
        cyc(1, 0, 50, 1, 0); cyc(1, 0, 60, 0, 0); cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 70, 0, 0); cyc(1, 1, 2, 0, 0); cyc(1, 1, 3, 0, 0);
        check_head("bridge", 0, 4);
        check("bridge_rmin", 32'(bus.obj_r_min), 50);
        cyc(0, 0, 0, 0, 1);

        // Gap exceeded: two separate runs
        cyc(1, 0, 300, 1, 0); cyc(1, 0, 301, 0, 0); cyc(1, 0, 302, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 303, 0, 0); cyc(1, 0, 304, 0, 0); cyc(1, 0, 305, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        check_head("gapx_first", 0, 3);
        cyc(0, 0, 0, 0, 1);
        check_head("gapx_second", 5, 3);
        cyc(0, 0, 0, 0, 1);

        // Frame boundary: run 36..40 closed by a non-ground frame start
        cyc(1, 1, 0, 1, 0);
        for (int i = 1; i < 36; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 200 + i, 0, 0);
        cyc(1, 0, 150, 1, 0);
        check_head("frame_close", 36, 5);
        cyc(1, 0, 151, 0, 0); cyc(1, 0, 152, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check_head("frame_new", 0, 3);
        cyc(0, 0, 0, 0, 1);

        // Backpressure: five qualifying runs into a four-deep queue
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) cyc(1, 0, int'($urandom_range(65535)), 0, 0);
            cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
        end
        check("bp_overflow", 32'(bus.overflow), 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1);
        check("bp_drained", 32'(bus.obj_valid), 0);
        check("bp_ovf_sticky", 32'(bus.overflow), 1);

        // Reset in the middle of an open run
        cyc(1, 0, 10, 0, 1); cyc(1, 0, 11, 0, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(3) != 0, $urandom_range(1) == 1,
                int'($urandom_range(65535)), $urandom_range(63) == 0,
                $urandom_range(3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
